// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges ALU and memory results into one register-file
// write port. Each source has a single-entry buffer; when both buffers are
// full the older entry wins, and a same-edge tie goes to memory.
module wb_arbiter #(
    parameter int unsigned WIDTH         = 16,
    parameter int unsigned VECTOR_LENGTH = 16
) (
    input  logic                             clk,
    input  logic                             rst,

    input  logic                             alu_valid,
    output logic                             alu_ready,
    input  logic [3:0]                       alu_rd,
    input  logic                             alu_vecop,
    input  logic [WIDTH-1:0]                 alu_scalar,
    input  logic [WIDTH*VECTOR_LENGTH-1:0]   alu_vector,

    input  logic                             mem_valid,
    output logic                             mem_ready,
    input  logic [3:0]                       mem_rd,
    input  logic                             mem_vecop,
    input  logic [WIDTH-1:0]                 mem_scalar,
    input  logic [WIDTH*VECTOR_LENGTH-1:0]   mem_vector,

    output logic                             wb_valid,
    output logic [3:0]                       wb_rd,
    output logic                             wb_vecop,
    output logic [WIDTH-1:0]                 wb_scalar,
    output logic [WIDTH*VECTOR_LENGTH-1:0]   wb_vector,
    output logic                             wb_aluop,
    output logic [7:0]                       conflict_cnt
);

    localparam int unsigned VW = WIDTH * VECTOR_LENGTH;

    // Source buffers
    logic               alu_full_q, alu_full_d;
    logic [3:0]         alu_rd_q;
    logic               alu_vecop_q;
    logic [WIDTH-1:0]   alu_scalar_q;
    logic [VW-1:0]      alu_vector_q;

    logic               mem_full_q, mem_full_d;
    logic [3:0]         mem_rd_q;
    logic               mem_vecop_q;
    logic [WIDTH-1:0]   mem_scalar_q;
    logic [VW-1:0]      mem_vector_q;

    // Set when the ALU entry was filled at an earlier edge than the memory entry.
    logic               alu_first_q, alu_first_d;

    logic               grant_alu, grant_mem;
    logic               alu_hs, mem_hs;

    // Grant decision from registered state only, so valid never reaches ready.
    always_comb begin
        grant_alu = alu_full_q & (~mem_full_q | alu_first_q);
        grant_mem = mem_full_q & (~alu_full_q | ~alu_first_q);
        alu_ready = ~alu_full_q | grant_alu;
        mem_ready = ~mem_full_q | grant_mem;
        alu_hs    = alu_valid & alu_ready;
        mem_hs    = mem_valid & mem_ready;
    end

    // Next full flags and relative age of the two entries.
    always_comb begin
        alu_full_d = alu_full_q;
        if (grant_alu) alu_full_d = 1'b0;
        if (alu_hs)    alu_full_d = 1'b1;

        mem_full_d = mem_full_q;
        if (grant_mem) mem_full_d = 1'b0;
        if (mem_hs)    mem_full_d = 1'b1;

        alu_first_d = alu_first_q;
        if (alu_hs && mem_hs) begin
            alu_first_d = 1'b0;          // same-edge tie: memory treated as older
        end else if (alu_hs) begin
            alu_first_d = ~mem_full_d;   // a surviving memory entry is older
        end else if (mem_hs) begin
            alu_first_d = alu_full_d;    // a surviving ALU entry is older
        end
    end

    // Buffer state, age tracking and payload capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_full_q  <= 1'b0;
            mem_full_q  <= 1'b0;
            alu_first_q <= 1'b0;
        end else begin
            alu_full_q  <= alu_full_d;
            mem_full_q  <= mem_full_d;
            alu_first_q <= alu_first_d;
            if (alu_hs) begin
                alu_rd_q     <= alu_rd;
                alu_vecop_q  <= alu_vecop;
                alu_scalar_q <= alu_scalar;
                alu_vector_q <= alu_vector;
            end
            if (mem_hs) begin
                mem_rd_q     <= mem_rd;
                mem_vecop_q  <= mem_vecop;
                mem_scalar_q <= mem_scalar;
                mem_vector_q <= mem_vector;
            end
        end
    end

    // Registered write-back port; payload holds when nothing is granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid  <= 1'b0;
            wb_rd     <= '0;
            wb_vecop  <= 1'b0;
            wb_scalar <= '0;
            wb_vector <= '0;
            wb_aluop  <= 1'b0;
        end else if (grant_mem) begin
            wb_valid  <= 1'b1;
            wb_rd     <= mem_rd_q;
            wb_vecop  <= mem_vecop_q;
            wb_scalar <= mem_scalar_q;
            wb_vector <= mem_vector_q;
            wb_aluop  <= 1'b0;
        end else if (grant_alu) begin
            wb_valid  <= 1'b1;
            wb_rd     <= alu_rd_q;
            wb_vecop  <= alu_vecop_q;
            wb_scalar <= alu_scalar_q;
            wb_vector <= alu_vector_q;
            wb_aluop  <= 1'b1;
        end else begin
            wb_valid  <= 1'b0;
        end
    end

    // Saturating count of cycles with both buffers occupied.
    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_cnt <= 8'd0;
        end else if (alu_full_q && mem_full_q && (conflict_cnt != 8'hFF)) begin
            conflict_cnt <= conflict_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: single result, tie, age order, streaming,
// saturation and mid-operation reset.
module tb_wb_arbiter;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned VLEN  = 16;
    localparam int unsigned VW    = WIDTH * VLEN;

    logic             clk = 1'b0;
    logic             rst;
    logic             alu_valid, alu_ready, alu_vecop;
    logic [3:0]       alu_rd;
    logic [WIDTH-1:0] alu_scalar;
    logic [VW-1:0]    alu_vector;
    logic             mem_valid, mem_ready, mem_vecop;
    logic [3:0]       mem_rd;
    logic [WIDTH-1:0] mem_scalar;
    logic [VW-1:0]    mem_vector;
    logic             wb_valid, wb_vecop, wb_aluop;
    logic [3:0]       wb_rd;
    logic [WIDTH-1:0] wb_scalar;
    logic [VW-1:0]    wb_vector;
    logic [7:0]       conflict_cnt;

    int checks = 0;
    int errors = 0;

    wb_arbiter #(.WIDTH(WIDTH), .VECTOR_LENGTH(VLEN)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd),
        .alu_vecop(alu_vecop), .alu_scalar(alu_scalar), .alu_vector(alu_vector),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd),
        .mem_vecop(mem_vecop), .mem_scalar(mem_scalar), .mem_vector(mem_vector),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_vecop(wb_vecop),
        .wb_scalar(wb_scalar), .wb_vector(wb_vector), .wb_aluop(wb_aluop),
        .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [VW-1:0] vec_of(input int k);
        logic [VW-1:0] v;
        for (int l = 0; l < VLEN; l++) begin
            v[l*WIDTH +: WIDTH] = {k[7:0], l[7:0]};
        end
        return v;
    endfunction

    initial begin
        rst = 1'b1;
        alu_valid = 0; alu_rd = 0; alu_vecop = 0; alu_scalar = 0; alu_vector = '0;
        mem_valid = 0; mem_rd = 0; mem_vecop = 0; mem_scalar = 0; mem_vector = '0;
        tick();
        // A handshake offered during reset must be dropped.
        alu_valid = 1; alu_rd = 4'd9; alu_scalar = 16'hDEAD;
        tick();
        rst = 0; alu_valid = 0;
        check("rst_wb_valid", wb_valid, 0);
        check("rst_wb_rd", wb_rd, 0);
        check("rst_wb_scalar", wb_scalar, 0);
        check("rst_wb_vector", wb_vector, 0);
        check("rst_wb_aluop", wb_aluop, 0);
        check("rst_conflict", conflict_cnt, 0);
        check("rst_alu_ready", alu_ready, 1);
        check("rst_mem_ready", mem_ready, 1);
        tick();
        check("rst_ignore_c1", wb_valid, 0);
        tick();
        check("rst_ignore_c2", wb_valid, 0);

        // Single ALU result: written in cycle 2 only.
        alu_valid = 1; alu_rd = 4'd3; alu_scalar = 16'h00A5;
        tick();
        alu_valid = 0;
        check("single_c1_valid", wb_valid, 0);
        tick();
        check("single_c2_valid", wb_valid, 1);
        check("single_c2_rd", wb_rd, 3);
        check("single_c2_scalar", wb_scalar, 16'h00A5);
        check("single_c2_aluop", wb_aluop, 1);
        tick();
        check("single_c3_valid", wb_valid, 0);
        check("single_hold_scalar", wb_scalar, 16'h00A5);

        // Same-edge arrival, same rd: memory first, ALU next.
        alu_valid = 1; alu_rd = 4'd5; alu_scalar = 16'h1111;
        mem_valid = 1; mem_rd = 4'd5; mem_scalar = 16'h2222;
        tick();
        mem_valid = 0; alu_scalar = 16'h3333;
        check("tie_alu_ready_c1", alu_ready, 0);
        check("tie_mem_ready_c1", mem_ready, 1);
        tick();
        check("tie_first_valid", wb_valid, 1);
        check("tie_first_aluop", wb_aluop, 0);
        check("tie_first_scalar", wb_scalar, 16'h2222);
        check("tie_conflict", conflict_cnt, 1);
        check("tie_alu_ready_c2", alu_ready, 1);
        tick();
        alu_valid = 0;
        check("tie_second_aluop", wb_aluop, 1);
        check("tie_second_scalar", wb_scalar, 16'h1111);
        check("tie_second_rd", wb_rd, 5);
        tick();
        check("tie_third_scalar", wb_scalar, 16'h3333);
        check("tie_conflict_after", conflict_cnt, 1);
        tick();
        check("tie_idle", wb_valid, 0);

        // Age order: entries written in order of their fill edge.
        alu_valid = 1; alu_rd = 4'd7; alu_scalar = 16'hA001;
        mem_valid = 1; mem_rd = 4'd8; mem_scalar = 16'hB001;
        tick();
        mem_rd = 4'd9; mem_scalar = 16'hB002;
        check("age_alu_ready_a", alu_ready, 0);
        tick();
        mem_valid = 0; alu_rd = 4'd10; alu_scalar = 16'hA002;
        check("age_w1", wb_scalar, 16'hB001);
        check("age_alu_ready_b", alu_ready, 1);
        check("age_mem_ready_b", mem_ready, 0);
        tick();
        alu_valid = 0;
        check("age_w2", wb_scalar, 16'hA001);
        check("age_w2_aluop", wb_aluop, 1);
        tick();
        check("age_w3", wb_scalar, 16'hB002);
        check("age_w3_aluop", wb_aluop, 0);
        tick();
        check("age_w4", wb_scalar, 16'hA002);
        check("age_w4_rd", wb_rd, 10);
        check("age_conflict", conflict_cnt, 4);
        tick();
        check("age_idle", wb_valid, 0);

        // Memory streaming vectors for 10 cycles.
        mem_valid = 1; mem_vecop = 1;
        for (int i = 0; i < 10; i++) begin
            mem_rd = i[3:0]; mem_scalar = 16'hC000 + 16'(i); mem_vector = vec_of(i);
            check("stream_mem_ready", mem_ready, 1);
            tick();
            if (i >= 1) begin
                check("stream_valid", wb_valid, 1);
                check("stream_vecop", wb_vecop, 1);
                check("stream_vector", wb_vector, vec_of(i - 1));
                check("stream_lane5", wb_vector[5*WIDTH +: WIDTH], {8'(i - 1), 8'd5});
            end else begin
                check("stream_start", wb_valid, 0);
            end
        end
        mem_valid = 0;
        tick();
        check("stream_last_vector", wb_vector, vec_of(9));
        check("stream_last_rd", wb_rd, 9);
        tick();
        check("stream_idle", wb_valid, 0);
        check("stream_conflict", conflict_cnt, 4);
        mem_vecop = 0;

        // Both sources saturating for 300 cycles.
        alu_valid = 1; mem_valid = 1;
        for (int k = 1; k <= 300; k++) begin
            tick();
            if (k >= 2) begin
                check("sat_valid", wb_valid, 1);
                check("sat_alternate", wb_aluop, (k % 2) == 1);
            end
            if (k == 100) check("sat_conflict_mid", conflict_cnt, 103);
        end
        check("sat_conflict_final", conflict_cnt, 255);

        // Reset with both buffers occupied.
        rst = 1;
        tick();
        rst = 0; alu_valid = 0; mem_valid = 0;
        check("midrst_valid", wb_valid, 0);
        check("midrst_alu_ready", alu_ready, 1);
        check("midrst_mem_ready", mem_ready, 1);
        check("midrst_conflict", conflict_cnt, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("midrst_no_write", wb_valid, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 16, element width in bits.
REQ-002 SHALL have parameter VECTOR_LENGTH, default 16, elements per vector.
REQ-003 SHALL use one clock and a synchronous, active-high reset, with ports: clk  input  1  rising-edge clock; rst  input  1  synchronous active-high reset.
REQ-004 SHALL have alu_valid  input  1  ALU result offered.
REQ-005 SHALL have alu_ready  output  1  ALU result accepted this cycle when alu_valid=1.
REQ-006 SHALL have alu_rd, alu_vecop, alu_scalar, alu_vector  input  4 / 1 / WIDTH / WIDTH x VECTOR_LENGTH  ALU destination, vector flag, scalar result, vector result.
REQ-007 SHALL have mem_valid  input  1, and mem_ready  output  1, with the same meanings as alu_valid and alu_ready for the memory source.
REQ-008 SHALL have mem_rd, mem_vecop, mem_scalar, mem_vector  input  4 / 1 / WIDTH / WIDTH x VECTOR_LENGTH  memory destination, vector flag, scalar result, vector result.
REQ-009 SHALL have wb_valid  output  1  register-file write strobe, one cycle per result.
REQ-010 SHALL have wb_rd, wb_vecop, wb_scalar, wb_vector  output  4 / 1 / WIDTH / WIDTH x VECTOR_LENGTH  write payload.
REQ-011 SHALL have wb_aluop  output  1  source of the write (1=ALU, 0=memory), matching the write-back mux select encoding.
REQ-012 SHALL have conflict_cnt  output  8  saturating count of contention cycles.

Function
REQ-013 SHALL hold one single-entry buffer per source (payload plus full flag).
REQ-014 SHALL treat a source handshake as complete when x_valid and x_ready are both 1 at a rising edge; the payload is captured into that source's buffer and the full flag is set.
REQ-015 SHALL compute x_ready = !x_full | x_grant, where the grant depends only on the registered full and age state and never on any *_valid input (no combinational valid-to-ready path).
REQ-016 SHALL grant at most one buffer per cycle: only one full -> that one; both full -> the older (full set at an earlier edge); both set at the same edge -> memory.
REQ-017 SHALL register the granted buffer's payload into wb_* at the next edge with wb_valid=1, and clear the granted full flag at that edge unless a new handshake on that source refills it.
REQ-018 SHALL give a latency of exactly 2 cycles from a handshake edge to the wb_valid cycle when uncontended.
REQ-019 SHALL sustain 1 write per cycle; a continuously streaming single source is never stalled.
REQ-020 SHALL drive wb_valid=0 in the cycle after a cycle with no grant; wb_* payload is don't-care when wb_valid=0 but SHALL hold its last value.
REQ-021 SHALL pass scalar and vector payloads unchanged; wb_vecop equals the buffered vecop flag, and wb_scalar and wb_vector are both driven from the same source.
REQ-022 SHALL increment conflict_cnt by 1 in every cycle in which both buffers are full, saturating at 255 with no wrap-around.
REQ-023 SHALL, for same-rd results from both sources, write the older first, so the later write wins in the register file.

Reset
REQ-024 SHALL, when rst=1 at an edge, clear both full flags and the age state, set wb_valid=0, wb_rd=0, wb_vecop=0, wb_aluop=0, wb_scalar=0, wb_vector all 0, and conflict_cnt=0.
REQ-025 SHALL hold alu_ready=mem_ready=1 after reset, and SHALL ignore any handshake presented in a reset cycle.
REQ-026 SHALL discard buffered results on reset mid-operation, with no wb_valid pulse afterwards for them.

Verification
REQ-027 SHALL be verified on the ALU single result: alu_valid=1, alu_rd=3, alu_scalar=16'h00A5 at edge 1 -> wb_valid=1, wb_rd=3, wb_scalar=16'h00A5, wb_aluop=1 in cycle 2 only.
REQ-028 SHALL be verified on simultaneous arrival: both valid at the same edge, alu_rd=5, mem_rd=5 -> memory written first (wb_aluop=0), ALU next cycle (wb_aluop=1); conflict_cnt=1; alu_ready=0 for one cycle only if ALU presents again.
REQ-029 SHALL be verified on age order: memory accepted at edge 1 while its buffer is held, then ALU at edge 2, contending -> memory written before ALU.
REQ-030 SHALL be verified on streaming: mem_valid=1 for 10 cycles with vector payloads, mem_vecop=1 -> 10 consecutive wb_valid cycles, wb_vecop=1, vectors intact lane-by-lane, mem_ready constantly 1.
REQ-031 SHALL be verified on saturation: both sources held valid for 300 cycles -> conflict_cnt stops at 255, and writes alternate by age.
REQ-032 SHALL be verified on reset mid-operation: both buffers full, rst=1 for one edge -> wb_valid=0 next cycle, both ready=1, conflict_cnt=0, and the old results are never written.
